// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types, default timing constants and helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  // FSM state encoding; also driven out on the debug state port.
  typedef enum logic [1:0] {
    S_PLL_RST   = 2'b00,
    S_WAIT_LOCK = 2'b01,
    S_RUN       = 2'b10,
    S_CNT_RST   = 2'b11
  } seq_state_e;

  // Default cycle constants for a 50 MHz clock.
  localparam int DEF_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int DEF_RST_PULSE_CYCLES    = 500;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 5_000_000;

  // Width of a counter that has to reach p-1; never narrower than one bit.
  function automatic int cnt_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low key: the level follows the input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; press pulses on a 1->0 flip.
module key_debounce
  import pll_reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic level,
  output logic press
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Next-state: count consecutive disagreeing cycles, flip the level on the last one.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (in_n != level_q) begin
      if (cnt_q >= LAST) begin
        level_d = in_n;
        press_d = ~in_n;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; an idle key reads as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Upstream reset controller: debounced keys, minimum-width PLL reset, lock-qualified
// counter reset release, lock-loss counting and a sticky lock-timeout flag.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  input  logic [1:0] remote_key_n,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       counter_reset_n,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count,
  output logic       lock_timeout
);

  localparam int            PW          = cnt_width(RST_PULSE_CYCLES);
  localparam int            SW          = cnt_width(LOCK_STABLE_CYCLES);
  localparam int            TW          = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);

  // Synchronizer stages.
  logic [1:0] key_meta_q, key_sync_q;
  logic [1:0] rkey_meta_q, rkey_sync_q;
  logic       lock_meta_q, locked_s;

  // Conditioned key signals.
  logic [1:0] kc;
  logic [1:0] key_level;
  logic [1:0] key_press;

  // FSM, counters and registered outputs.
  seq_state_e    state_q, state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] tout_cnt_q, tout_cnt_d;
  logic [7:0]    loss_cnt_q, loss_cnt_d;
  logic          timeout_q, timeout_d;
  logic          pll_reset_q, pll_reset_d;
  logic          crst_n_q, crst_n_d;

  // Two-flop synchronizers for the asynchronous key and lock inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q  <= 2'b11;
      key_sync_q  <= 2'b11;
      rkey_meta_q <= 2'b11;
      rkey_sync_q <= 2'b11;
      lock_meta_q <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      key_meta_q  <= key_n;
      key_sync_q  <= key_meta_q;
      rkey_meta_q <= remote_key_n;
      rkey_sync_q <= rkey_meta_q;
      lock_meta_q <= pll_locked;
      locked_s    <= lock_meta_q;
    end
  end

  // A key counts as pressed if either the board or the remote source pulls it low.
  assign kc = key_sync_q & rkey_sync_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .clk   (clk),
    .rst   (rst),
    .in_n  (kc[0]),
    .level (key_level[0]),
    .press (key_press[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk   (clk),
    .rst   (rst),
    .in_n  (kc[1]),
    .level (key_level[1]),
    .press (key_press[1])
  );

  // Next-state, counters and outputs; key0 > lock loss > key1 > timers.
  always_comb begin
    state_d      = state_q;
    loss_cnt_d   = loss_cnt_q;
    timeout_d    = timeout_q;
    pulse_cnt_d  = '0;
    stable_cnt_d = '0;
    tout_cnt_d   = '0;

    unique case (state_q)
      S_PLL_RST: begin
        if (pulse_cnt_q >= PULSE_LAST && key_level[0]) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (key_press[0]) begin
          state_d = S_PLL_RST;
        end else if (locked_s && stable_cnt_q >= STABLE_LAST) begin
          state_d = S_RUN;
        end else if (tout_cnt_q >= TOUT_LAST) begin
          state_d   = S_PLL_RST;
          timeout_d = 1'b1;
        end
      end
      S_RUN: begin
        if (key_press[0]) begin
          state_d = S_PLL_RST;
        end else if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end else if (key_press[1]) begin
          state_d = S_CNT_RST;
        end
      end
      S_CNT_RST: begin
        if (key_press[0]) begin
          state_d = S_PLL_RST;
        end else if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (key_level[1]) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    if (key_press[0]) timeout_d = 1'b0;

    // Counters restart on every state entry and saturate at their terminal value.
    // The pulse counter only runs while KEY0 is released, so a held key stretches the pulse.
    if (state_d == state_q) begin
      if (state_q == S_PLL_RST && key_level[0])
        pulse_cnt_d = (pulse_cnt_q >= PULSE_LAST) ? pulse_cnt_q : pulse_cnt_q + 1'b1;
      if (state_q == S_WAIT_LOCK) begin
        if (locked_s)
          stable_cnt_d = (stable_cnt_q >= STABLE_LAST) ? stable_cnt_q : stable_cnt_q + 1'b1;
        tout_cnt_d = (tout_cnt_q >= TOUT_LAST) ? tout_cnt_q : tout_cnt_q + 1'b1;
      end
    end

    pll_reset_d = (state_d == S_PLL_RST);
    crst_n_d    = (state_d == S_RUN);
  end

  // FSM state, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every counter is reset explicitly; none of them may start from an unknown value.
      state_q      <= S_PLL_RST;
      pulse_cnt_q  <= '0;
      stable_cnt_q <= '0;
      tout_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      pll_reset_q  <= 1'b1;
      crst_n_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      tout_cnt_q   <= tout_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      timeout_q    <= timeout_d;
      pll_reset_q  <= pll_reset_d;
      crst_n_q     <= crst_n_d;
    end
  end

  assign pll_reset       = pll_reset_q;
  assign counter_reset_n = crst_n_q;
  assign state           = state_q;
  assign lock_loss_count = loss_cnt_q;
  assign lock_timeout    = timeout_q;

endmodule
